// File: rtl/l1_trigger_register_pkg.sv
// l1_trigger_register_pkg
// Shared constants and helpers for the L1 trigger register slice.
//   DEPTH / PTR_W       : trigger FIFO depth and pointer width
//   BCID_W / TAG_W      : field widths of one stored entry
//   ENTRY_W             : packed {tag, bcid} entry width
//   tmr_vote()          : bitwise 2-of-3 majority, up to TMR_W bits wide
package l1_trigger_register_pkg;

  localparam int DEPTH   = 16;
  localparam int PTR_W   = 4;
  localparam int BCID_W  = 8;
  localparam int MISS_W  = 8;
  localparam int TAG_W   = 4;
  localparam int ENTRY_W = TAG_W + BCID_W;

  // Widest value the voter handles; narrower callers zero-extend their
  // operands and truncate the result back to their own width.
  localparam int TMR_W   = 8;

  function automatic logic [TMR_W-1:0] tmr_vote(
    input logic [TMR_W-1:0] a,
    input logic [TMR_W-1:0] b,
    input logic [TMR_W-1:0] c
  );
    return (a & b) | (b & c) | (a & c);
  endfunction

endpackage

// File: rtl/l1_trigger_register_if.sv
// l1_trigger_register_if
// Trigger-in / readout-out handshake bundle of the L1 trigger register.
//   L1, L1In, BCID   : trigger strobe with the tag and bunch crossing to store
//   Rd_Ack           : readout pops the head entry
//   Rd_Valid         : head entry present
//   Rd_L1In, Rd_BCID : head entry contents (show-ahead)
//   L1_Reg_Full      : register full; gates triggers and the upstream counter
// master = trigger source / readout controller side, slave = the register.
interface l1_trigger_register_if #(
  parameter int BCID_W = 8
);
  logic              L1;
  logic [3:0]        L1In;
  logic [BCID_W-1:0] BCID;
  logic              Rd_Ack;
  logic              Rd_Valid;
  logic [3:0]        Rd_L1In;
  logic [BCID_W-1:0] Rd_BCID;
  logic              L1_Reg_Full;

  modport master (
    output L1, L1In, BCID, Rd_Ack,
    input  Rd_Valid, Rd_L1In, Rd_BCID, L1_Reg_Full
  );

  modport slave (
    input  L1, L1In, BCID, Rd_Ack,
    output Rd_Valid, Rd_L1In, Rd_BCID, L1_Reg_Full
  );
endinterface

// File: rtl/l1_trigger_register_tmr_voted_reg.sv
// tmr_voted_reg
// W-bit triple-redundant register with majority-voted output.
//   Clk, Reset : clock, asynchronous active-low reset (all copies -> 0)
//   d          : next value, computed by the owner from the voted q
//   q          : bitwise majority of the three copies
//   mismatch   : any copy differs from its siblings (combinational)
// Because every copy reloads from a value derived from q, a single upset
// copy is overwritten with the voted value at the next posedge.
module tmr_voted_reg
  import l1_trigger_register_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         mismatch
);

  logic [W-1:0] copy_a_reg;
  logic [W-1:0] copy_b_reg;
  logic [W-1:0] copy_c_reg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      copy_a_reg <= '0;
      copy_b_reg <= '0;
      copy_c_reg <= '0;
    end else begin
      copy_a_reg <= d;
      copy_b_reg <= d;
      copy_c_reg <= d;
    end
  end

  assign q = W'(tmr_vote(TMR_W'(copy_a_reg), TMR_W'(copy_b_reg), TMR_W'(copy_c_reg)));

  assign mismatch = (copy_a_reg != copy_b_reg) || (copy_b_reg != copy_c_reg);

endmodule

// File: rtl/l1_trigger_register.sv
// l1_trigger_register
// Show-ahead FIFO of accepted L1 triggers, each entry {L1In tag, BCID}.
//   Clk, Reset  : clock, asynchronous active-low reset
//   bus (slave) : L1/L1In/BCID in, Rd_Ack in, Rd_Valid/Rd_L1In/Rd_BCID out,
//                 L1_Reg_Full out
//   Occupancy   : voted entry count (0..DEPTH)
//   L1_Missed   : saturating count of L1 strobes seen while full
//   Error       : voted flag, set for one cycle span after any TMR copy upset
// wr_ptr, rd_ptr and count are triple-redundant; storage is not.
module l1_trigger_register
  import l1_trigger_register_pkg::*;
#(
  parameter int DEPTH  = l1_trigger_register_pkg::DEPTH,
  parameter int PTR_W  = l1_trigger_register_pkg::PTR_W,
  parameter int BCID_W = l1_trigger_register_pkg::BCID_W,
  parameter int MISS_W = l1_trigger_register_pkg::MISS_W
) (
  input  logic                      Clk,
  input  logic                      Reset,
  l1_trigger_register_if.slave      bus,
  output logic [PTR_W:0]            Occupancy,
  output logic [MISS_W-1:0]         L1_Missed,
  output logic                      Error
);

  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TAG_W + BCID_W;

  logic [PTR_W-1:0]  wr_ptr, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr, rd_ptr_next;
  logic [CNT_W-1:0]  count, count_next;
  logic              wr_mismatch, rd_mismatch, cnt_mismatch;
  logic              full, write_en, pop_en;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [MISS_W-1:0] missed_reg;
  logic              err_a_reg, err_b_reg, err_c_reg;

  assign full     = (count == CNT_W'(DEPTH));
  assign write_en = bus.L1 && !full;
  assign pop_en   = bus.Rd_Ack && (count != '0);

  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    if (write_en) wr_ptr_next = wr_ptr + PTR_W'(1);
    if (pop_en)   rd_ptr_next = rd_ptr + PTR_W'(1);
    // Simultaneous write and pop leaves the count unchanged.
    case ({write_en, pop_en})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  tmr_voted_reg #(.W(PTR_W)) u_wr_ptr (
    .Clk(Clk), .Reset(Reset), .d(wr_ptr_next), .q(wr_ptr), .mismatch(wr_mismatch)
  );

  tmr_voted_reg #(.W(PTR_W)) u_rd_ptr (
    .Clk(Clk), .Reset(Reset), .d(rd_ptr_next), .q(rd_ptr), .mismatch(rd_mismatch)
  );

  tmr_voted_reg #(.W(CNT_W)) u_count (
    .Clk(Clk), .Reset(Reset), .d(count_next), .q(count), .mismatch(cnt_mismatch)
  );

  // Storage is not reset; entries beyond the voted count are never shown
  // as valid.
  always_ff @(posedge Clk) begin
    if (write_en) mem[wr_ptr] <= {bus.L1In, bus.BCID};
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      missed_reg <= '0;
    end else if (bus.L1 && full && (missed_reg != '1)) begin
      missed_reg <= missed_reg + MISS_W'(1);
    end
  end

  // Mismatch is sampled on the falling edge, half a cycle after the copies
  // settle, so Error reports an upset for one cycle span while the copies
  // themselves heal at the next rising edge.
  always_ff @(negedge Clk or negedge Reset) begin
    if (!Reset) begin
      err_a_reg <= 1'b0;
      err_b_reg <= 1'b0;
      err_c_reg <= 1'b0;
    end else begin
      err_a_reg <= wr_mismatch || rd_mismatch || cnt_mismatch;
      err_b_reg <= wr_mismatch || rd_mismatch || cnt_mismatch;
      err_c_reg <= wr_mismatch || rd_mismatch || cnt_mismatch;
    end
  end

  assign Error = 1'(tmr_vote(TMR_W'(err_a_reg), TMR_W'(err_b_reg), TMR_W'(err_c_reg)));

  assign bus.Rd_Valid    = (count != '0);
  assign bus.L1_Reg_Full = full;
  assign {bus.Rd_L1In, bus.Rd_BCID} = mem[rd_ptr];
  assign Occupancy       = count;
  assign L1_Missed       = missed_reg;

endmodule

// File: tb/tb_l1_trigger_register.sv
// tb_l1_trigger_register
// Directed vectors for the L1 trigger register: a table for basic
// store/readout/empty-ack behaviour, then hand sequences for fill/overflow,
// full with simultaneous pop, a single-copy upset, and mid-run reset.
module tb_l1_trigger_register;
  import l1_trigger_register_pkg::*;

  logic Clk;
  logic Reset;
  logic [4:0] Occupancy;
  logic [7:0] L1_Missed;
  logic       Error;

  int tests_run    = 0;
  int tests_failed = 0;

  l1_trigger_register_if #(.BCID_W(8)) bus ();

  l1_trigger_register dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus),
    .Occupancy(Occupancy),
    .L1_Missed(L1_Missed),
    .Error(Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       l1;
    logic [3:0] tag;
    logic [7:0] bcid;
    logic       ack;
    logic       exp_valid;
    logic [3:0] exp_tag;
    logic [7:0] exp_bcid;
    logic [4:0] exp_occ;
    logic       exp_full;
    logic [7:0] exp_missed;
  } vec_t;

  vec_t vecs [13];
  logic [11:0] q [$];

  function automatic logic [3:0] gray4(input int i);
    logic [3:0] b;
    b = 4'(i);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic exp_valid,
                             input logic [3:0] exp_tag, input logic [7:0] exp_bcid,
                             input logic [4:0] exp_occ, input logic exp_full,
                             input logic [7:0] exp_missed);
    check({name, ".valid"}, 32'(bus.Rd_Valid), 32'(exp_valid));
    check({name, ".occ"}, 32'(Occupancy), 32'(exp_occ));
    check({name, ".full"}, 32'(bus.L1_Reg_Full), 32'(exp_full));
    check({name, ".missed"}, 32'(L1_Missed), 32'(exp_missed));
    if (exp_valid) begin
      check({name, ".tag"}, 32'(bus.Rd_L1In), 32'(exp_tag));
      check({name, ".bcid"}, 32'(bus.Rd_BCID), 32'(exp_bcid));
    end
    $display("[TB] %s occ=%0d valid=%0b head=%0h/%0h missed=%0d err=%0b",
             name, Occupancy, bus.Rd_Valid, bus.Rd_L1In, bus.Rd_BCID, L1_Missed, Error);
  endtask

  // Drive one cycle of inputs, take the rising edge, sample just after it.
  task automatic step(input logic l1, input logic [3:0] tag, input logic [7:0] bcid,
                      input logic ack);
    bus.L1     = l1;
    bus.L1In   = tag;
    bus.BCID   = bcid;
    bus.Rd_Ack = ack;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.L1     = 1'b0;
    bus.L1In   = 4'h0;
    bus.BCID   = 8'h00;
    bus.Rd_Ack = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    q.delete();
  endtask

  // Compare head against the queue model, 'head' meaning q[0] when present.
  task automatic check_model(input string name, input logic [7:0] exp_missed);
    logic [11:0] h;
    h = (q.size() != 0) ? q[0] : 12'h000;
    check_state(name, q.size() != 0, h[11:8], h[7:0], 5'(q.size()),
                q.size() == 16, exp_missed);
  endtask

  initial begin
    Reset = 1'b0;
    idle();
    #1;
    check_state("reset", 1'b0, 4'h0, 8'h00, 5'd0, 1'b0, 8'd0);
    check("reset.error", 32'(Error), 32'd0);
    do_reset();

    // Three triggers, drain, then Rd_Ack on empty, then one more trigger.
    vecs[0]  = '{1'b1, 4'h0, 8'h10, 1'b0,  1'b1, 4'h0, 8'h10, 5'd1, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 4'h1, 8'h20, 1'b0,  1'b1, 4'h0, 8'h10, 5'd2, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 4'h3, 8'h30, 1'b0,  1'b1, 4'h0, 8'h10, 5'd3, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 4'h0, 8'h00, 1'b1,  1'b1, 4'h1, 8'h20, 5'd2, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 4'h0, 8'h00, 1'b1,  1'b1, 4'h3, 8'h30, 5'd1, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 4'h0, 8'h00, 1'b1,  1'b0, 4'h0, 8'h00, 5'd0, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 4'h0, 8'h00, 1'b1,  1'b0, 4'h0, 8'h00, 5'd0, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 4'h0, 8'h00, 1'b1,  1'b0, 4'h0, 8'h00, 5'd0, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 4'h0, 8'h00, 1'b1,  1'b0, 4'h0, 8'h00, 5'd0, 1'b0, 8'd0};
    vecs[9]  = '{1'b0, 4'h0, 8'h00, 1'b1,  1'b0, 4'h0, 8'h00, 5'd0, 1'b0, 8'd0};
    vecs[10] = '{1'b0, 4'h0, 8'h00, 1'b1,  1'b0, 4'h0, 8'h00, 5'd0, 1'b0, 8'd0};
    vecs[11] = '{1'b1, 4'h2, 8'h40, 1'b0,  1'b1, 4'h2, 8'h40, 5'd1, 1'b0, 8'd0};
    vecs[12] = '{1'b0, 4'h0, 8'h00, 1'b1,  1'b0, 4'h0, 8'h00, 5'd0, 1'b0, 8'd0};

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].l1, vecs[i].tag, vecs[i].bcid, vecs[i].ack);
      check_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_tag,
                  vecs[i].exp_bcid, vecs[i].exp_occ, vecs[i].exp_full, vecs[i].exp_missed);
    end

    // Fill to 16 back-to-back; pointers start at 4 so they wrap while filling.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, gray4(i), 8'h80 + 8'(i), 1'b0);
      q.push_back({gray4(i), 8'h80 + 8'(i)});
      check_model($sformatf("fill%0d", i), 8'd0);
    end
    step(1'b1, 4'hF, 8'hEE, 1'b0);
    check_model("ovf17", 8'd1);
    step(1'b1, 4'hF, 8'hEF, 1'b0);
    check_model("ovf18", 8'd2);

    // Full: trigger rejected while the pop goes through.
    step(1'b1, 4'hE, 8'hDD, 1'b1);
    void'(q.pop_front());
    check_model("full_wr_pop", 8'd3);
    // Not full: both write and pop happen.
    step(1'b1, 4'hC, 8'hCC, 1'b1);
    void'(q.pop_front());
    q.push_back({4'hC, 8'hCC});
    check_model("wr_pop", 8'd3);

    for (int k = 0; k < 15; k++) begin
      step(1'b0, 4'h0, 8'h00, 1'b1);
      void'(q.pop_front());
      check_model($sformatf("drain%0d", k), 8'd3);
    end
    idle();

    // Single-copy upset on wr_ptr at occupancy 5.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, gray4(i), 8'hA0 + 8'(i), 1'b0);
      q.push_back({gray4(i), 8'hA0 + 8'(i)});
    end
    idle();
    check_model("seu_pre", 8'd0);
    check("seu_pre.error", 32'(Error), 32'd0);
    force dut.u_wr_ptr.copy_a_reg = 4'h4;
    @(negedge Clk);
    #1;
    check("seu.error_set", 32'(Error), 32'd1);
    check("seu.occ", 32'(Occupancy), 32'd5);
    release dut.u_wr_ptr.copy_a_reg;
    @(posedge Clk);
    @(negedge Clk);
    #1;
    check("seu.error_clear", 32'(Error), 32'd0);
    check_model("seu_post", 8'd0);
    // One more trigger proves the write pointer kept its voted value.
    step(1'b1, 4'h6, 8'hA5, 1'b0);
    q.push_back({4'h6, 8'hA5});
    check_model("seu_wr", 8'd0);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 4'h0, 8'h00, 1'b1);
      void'(q.pop_front());
      check_model($sformatf("seu_drain%0d", k), 8'd0);
    end
    idle();

    // Reset while holding 9 entries.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 4'(i), 8'h30 + 8'(i), 1'b0);
      q.push_back({4'(i), 8'h30 + 8'(i)});
    end
    idle();
    check_model("pre_rst", 8'd0);
    #2;
    Reset = 1'b0;
    #1;
    check_state("async_rst", 1'b0, 4'h0, 8'h00, 5'd0, 1'b0, 8'd0);
    q.delete();
    @(negedge Clk);
    Reset = 1'b1;
    step(1'b1, 4'h0, 8'h55, 1'b0);
    check_state("post_rst", 1'b1, 4'h0, 8'h55, 5'd1, 1'b0, 8'd0);
    idle();
    @(posedge Clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/l1_trigger_register.md
Name: l1_trigger_register

Overview:
- Downstream consumer of the triplicated Gray-coded L1In trigger counter.
- On each accepted L1 trigger, stores the current L1In tag and BCID as one entry in a show-ahead FIFO. The readout controller pops entries as it finishes each event.
- Produces L1_Reg_Full, which gates both trigger acceptance and the L1In counter increment.
- Pointers and occupancy are triple-redundant with majority voting and a voted mismatch Error flag, for SEU tolerance.

Parameters:
- DEPTH, 16: number of trigger entries; power of 2, 2..16.
- PTR_W, 4: log2(DEPTH).
- BCID_W, 8: BCID width.
- MISS_W, 8: width of the missed-trigger counter.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- L1  in  1  Level-1 trigger strobe, one Clk per trigger.
- L1In  in  4  Gray-coded trigger tag from the L1In counter.
- BCID  in  BCID_W  current bunch-crossing ID.
- Rd_Ack  in  1  readout pops the head entry.
- Rd_Valid  out  1  head entry valid (FIFO not empty).
- Rd_L1In  out  4  head entry tag, Gray code as stored.
- Rd_BCID  out  BCID_W  head entry BCID.
- L1_Reg_Full  out  1  occupancy == DEPTH.
- Occupancy  out  PTR_W+1  voted entry count.
- L1_Missed  out  MISS_W  saturating count of L1 received while full.
- Error  out  1  voted TMR mismatch flag.

Behaviour:
- Reset (async, Reset=0): all three copies of wr_ptr, rd_ptr and count go to 0. Rd_Valid=0, L1_Reg_Full=0, Occupancy=0, L1_Missed=0, Error=0. Storage contents are don't-care and are not reset.
- Reset mid-operation: all pending entries are discarded immediately. The upstream counter resets in the same way, so tags restart consistently.
- Accept: write_en = L1 && !L1_Reg_Full, evaluated at posedge Clk.
  - Captures {L1In, BCID} from the same cycle into mem[wr_ptr].
  - L1In in that cycle is the pre-increment value, so the first trigger after reset stores tag 4'h0.
- Pop: pop_en = Rd_Ack && Rd_Valid. Rd_Ack while empty is ignored and does not move rd_ptr.
- Show-ahead read: Rd_L1In/Rd_BCID = mem[rd_ptr] combinationally from the voted pointer.
  - Write-to-Rd_Valid latency is 1 Clk: an entry written at edge N is visible after edge N.
  - Rd_Valid = (count != 0).
- Simultaneous write and pop:
  - Not full: both happen, count unchanged, pointers both advance.
  - Full: write rejected (full is evaluated before the edge), pop happens, count = DEPTH-1.
- Overflow: L1 while L1_Reg_Full increments L1_Missed. It saturates at all-ones and clears only on Reset. No entry is written and the tag is not advanced (the upstream counter is gated by the same signal).
- Pointers are PTR_W bits and wrap DEPTH-1 -> 0. count ranges 0..DEPTH, is PTR_W+1 bits, and never exceeds DEPTH or goes below 0.
- TMR:
  - Each of wr_ptr, rd_ptr and count is held in 3 registers.
  - The bitwise majority vote drives all logic and outputs.
  - Every copy is updated from the voted value each posedge, so a single upset self-corrects within 1 Clk.
- Error:
  - On negedge Clk, the three triplicated error flops load 1 if any copy of any of the three registers differs from its siblings, else 0.
  - Error is the majority of those flops.
  - An injected single-copy upset gives Error=1 for one cycle span and no functional disturbance.
- L1_Reg_Full and Occupancy are decoded from the voted count and are glitch-free relative to posedge.

Decomposition:
- Shared package: the TMR majority function (3-input, N-bit), the entry record width (4+BCID_W), and the DEPTH/PTR_W constants.
- One natural sub-module, tmr_voted_reg: N-bit triplicated register with voter output and mismatch flag, instantiated for wr_ptr, rd_ptr and count.
- Storage is a plain register array inside the top module.

Test Plan:
- Reset, then 3 isolated L1s with L1In=0,1,3 (Gray) and BCID=0x10,0x20,0x30 -> Occupancy=3, Rd_Valid=1. Head is (0,0x10); three Rd_Acks yield (1,0x20) then (3,0x30), then Rd_Valid=0.
- 16 back-to-back L1s -> L1_Reg_Full=1 after the 16th edge. A 17th and 18th L1 -> L1_Missed=2, Occupancy stays 16. Drain all 16 -> tags in order, pointers wrap to 0.
- Full, then L1 and Rd_Ack in the same cycle -> Occupancy=15, L1_Missed+1, new tag not stored. Next cycle L1 and Rd_Ack -> Occupancy stays 15.
- Rd_Ack held high while empty for 5 cycles -> rd_ptr unchanged, no underflow. The next L1 gives Rd_Valid=1 one cycle later with the correct entry.
- Force one copy of wr_ptr to flip at occupancy 5 -> Error=1 after the following negedge, then Error=0. Readout order and Occupancy are unaffected.
- Assert Reset while Occupancy=9 -> Rd_Valid=0, Occupancy=0 immediately. After release, the first L1 with L1In=0 is stored at head.
